pe_rr_multi_arb: RTL and testbench

// - Round-robin, multi-grant arbiter built on the pe_lsb priority-encode primitive.
// - Picks up to NUM_ACKS requesters per cycle from req_vec, starting at a registered rotating pointer.
// - Optional burst lock pins grant slot 0 to one requester across cycles.
// - Serves issue queues, LSQ and writeback-port selection wherever fixed LSB priority would starve.

---
 rtl/pe_rr_multi_arb_pkg.sv | 12 +
 rtl/pe_rr_multi_arb_pe_lsb.sv | 23 ++
 rtl/pe_rr_multi_arb.sv | 157 +++++++++++++++
 tb/tb_pe_rr_multi_arb.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/pe_rr_multi_arb_pkg.sv
// Shared helpers for the round-robin multi-grant arbiter.
package pe_rr_multi_arb_pkg;

  // Modulo add for operands already below width; wraps at width, not at a power of two.
  function automatic int unsigned mod_add(input int unsigned a, input int unsigned b,
                                          input int unsigned width);
    int unsigned s;
    s = a + b;
    return (s >= width) ? (s - width) : s;
  endfunction

endpackage

// File: rtl/pe_rr_multi_arb_pe_lsb.sv
// Lowest-set-bit priority encoder; cold_ack_mask is the request vector with the winner removed.
module pe_lsb #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         req,
  output logic                     ack_valid,
  output logic [WIDTH-1:0]         ack_one_hot,
  output logic [$clog2(WIDTH)-1:0] ack_index,
  output logic [WIDTH-1:0]         cold_ack_mask
);
  localparam int IDX_W = $clog2(WIDTH);

  always_comb begin
    ack_valid     = |req;
    ack_one_hot   = req & (~req + {{(WIDTH-1){1'b0}}, 1'b1});
    ack_index     = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (ack_one_hot[i]) ack_index = IDX_W'(i);
    end
    cold_ack_mask = req & ~ack_one_hot;
  end

endmodule

// File: rtl/pe_rr_multi_arb.sv
// Round-robin arbiter granting up to NUM_ACKS requesters per cycle, with an optional
// burst lock that pins slot 0 to one requester.
module pe_rr_multi_arb
  import pe_rr_multi_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NUM_ACKS = 2
) (
  input  logic                                   CLK,
  input  logic                                   nRST,
  input  logic [WIDTH-1:0]                       req_vec,
  input  logic                                   ack_ready,
  input  logic                                   hold_req,
  output logic [NUM_ACKS-1:0]                    ack_valid,
  output logic [NUM_ACKS-1:0][WIDTH-1:0]         ack_one_hot,
  output logic [NUM_ACKS-1:0][$clog2(WIDTH)-1:0] ack_index,
  output logic [WIDTH-1:0]                       ack_mask_all,
  output logic [$clog2(WIDTH)-1:0]               rr_ptr,
  output logic                                   locked
);
  localparam int IDX_W = $clog2(WIDTH);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic             locked_q, locked_d;

  logic             eff_lock;
  logic [WIDTH-1:0] lock_oh;
  logic [WIDTH-1:0] rr_vec;
  logic [WIDTH-1:0] rot_vec;

  logic             chain_valid   [NUM_ACKS];
  logic [WIDTH-1:0] chain_oh_rot  [NUM_ACKS];
  logic [IDX_W-1:0] chain_idx_rot [NUM_ACKS];
  logic [WIDTH-1:0] chain_cold    [NUM_ACKS];
  logic [WIDTH-1:0] chain_oh      [NUM_ACKS];
  logic [IDX_W-1:0] chain_idx     [NUM_ACKS];

  logic             commit;
  logic             rr_found;
  logic [IDX_W-1:0] rr_last_idx;
  int               chain_used;
  int               src;

  assign lock_oh  = {{(WIDTH-1){1'b0}}, 1'b1} << lock_idx_q;
  assign eff_lock = locked_q & req_vec[lock_idx_q];
  assign rr_vec   = eff_lock ? (req_vec & ~lock_oh) : req_vec;

  // Rotate right so that the requester at rr_ptr lands on bit 0 of the chain input.
  always_comb begin
    rot_vec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rot_vec[i] = rr_vec[IDX_W'(mod_add(i, 32'(rr_ptr_q), WIDTH))];
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_ACKS; gi++) begin : g_chain
      if (gi == 0) begin : g_first
        pe_lsb #(.WIDTH(WIDTH)) u_pe (
          .req           (rot_vec),
          .ack_valid     (chain_valid[gi]),
          .ack_one_hot   (chain_oh_rot[gi]),
          .ack_index     (chain_idx_rot[gi]),
          .cold_ack_mask (chain_cold[gi])
        );
      end else begin : g_next
        pe_lsb #(.WIDTH(WIDTH)) u_pe (
          .req           (chain_cold[gi-1]),
          .ack_valid     (chain_valid[gi]),
          .ack_one_hot   (chain_oh_rot[gi]),
          .ack_index     (chain_idx_rot[gi]),
          .cold_ack_mask (chain_cold[gi])
        );
      end
    end
  endgenerate

  // Undo the rotation on every chain stage's result.
  always_comb begin
    for (int k = 0; k < NUM_ACKS; k++) begin
      chain_oh[k] = '0;
      for (int j = 0; j < WIDTH; j++) begin
        chain_oh[k][IDX_W'(mod_add(j, 32'(rr_ptr_q), WIDTH))] = chain_oh_rot[k][j];
      end
      chain_idx[k] = IDX_W'(mod_add(32'(chain_idx_rot[k]), 32'(rr_ptr_q), WIDTH));
    end
  end

  // Slot 0 carries the lock when it is live; chain stages shift up one slot in that case.
  always_comb begin
    ack_valid    = '0;
    ack_one_hot  = '0;
    ack_index    = '0;
    ack_mask_all = '0;
    src          = 0;
    for (int k = 0; k < NUM_ACKS; k++) begin
      if (eff_lock && k == 0) begin
        ack_valid[0]   = 1'b1;
        ack_one_hot[0] = lock_oh;
        ack_index[0]   = lock_idx_q;
      end else begin
        src = eff_lock ? k - 1 : k;
        if (chain_valid[src]) begin
          ack_valid[k]   = 1'b1;
          ack_one_hot[k] = chain_oh[src];
          ack_index[k]   = chain_idx[src];
        end
      end
      ack_mask_all = ack_mask_all | ack_one_hot[k];
    end
  end

  always_comb begin
    chain_used  = eff_lock ? NUM_ACKS - 1 : NUM_ACKS;
    rr_found    = 1'b0;
    rr_last_idx = '0;
    for (int k = 0; k < NUM_ACKS; k++) begin
      if (k < chain_used && chain_valid[k]) begin
        rr_found    = 1'b1;
        rr_last_idx = chain_idx[k];
      end
    end

    commit     = ack_ready & ack_valid[0];
    rr_ptr_d   = rr_ptr_q;
    locked_d   = locked_q;
    lock_idx_d = lock_idx_q;
    if (commit) begin
      if (rr_found) rr_ptr_d = IDX_W'(mod_add(32'(rr_last_idx), 1, WIDTH));
      if (hold_req) begin
        locked_d   = 1'b1;
        lock_idx_d = ack_index[0];
      end else begin
        locked_d   = 1'b0;
      end
    end else if (locked_q && !req_vec[lock_idx_q]) begin
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr_q   <= '0;
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  assign rr_ptr = rr_ptr_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_pe_rr_multi_arb.sv
// Scoreboard bench: a driver queues hand-computed expectations, a negedge monitor checks them.
module tb_pe_rr_multi_arb;

  logic CLK = 1'b0;
  logic nRST;
  logic [7:0] req_vec;
  logic ack_ready, hold_req;
  logic [1:0] ack_valid;
  logic [1:0][7:0] ack_one_hot;
  logic [1:0][2:0] ack_index;
  logic [7:0] ack_mask_all;
  logic [2:0] rr_ptr;
  logic locked;

  logic [5:0] req6;
  logic [1:0] ack_valid6;
  logic [1:0][5:0] ack_one_hot6;
  logic [1:0][2:0] ack_index6;
  logic [5:0] ack_mask_all6;
  logic [2:0] rr_ptr6;
  logic locked6;

  always #5 CLK = ~CLK;

  pe_rr_multi_arb #(.WIDTH(8), .NUM_ACKS(2)) dut (
    .CLK(CLK), .nRST(nRST), .req_vec(req_vec), .ack_ready(ack_ready), .hold_req(hold_req),
    .ack_valid(ack_valid), .ack_one_hot(ack_one_hot), .ack_index(ack_index),
    .ack_mask_all(ack_mask_all), .rr_ptr(rr_ptr), .locked(locked)
  );

  pe_rr_multi_arb #(.WIDTH(6), .NUM_ACKS(2)) dut6 (
    .CLK(CLK), .nRST(nRST), .req_vec(req6), .ack_ready(ack_ready), .hold_req(hold_req),
    .ack_valid(ack_valid6), .ack_one_hot(ack_one_hot6), .ack_index(ack_index6),
    .ack_mask_all(ack_mask_all6), .rr_ptr(rr_ptr6), .locked(locked6)
  );

  typedef struct {
    logic [7:0] req;
    logic [1:0] v;
    logic [2:0] i0, i1;
    logic [7:0] m;
    logic [2:0] p;
    logic       l;
    logic [5:0] r6;
    logic [1:0] v6;
    logic [2:0] i6, p6;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad = 0;
  int txn = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    logic [7:0] oh0, oh1;
    logic [5:0] oh6;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      oh0 = e.v[0] ? (8'd1 << e.i0) : 8'd0;
      oh1 = e.v[1] ? (8'd1 << e.i1) : 8'd0;
      oh6 = e.v6[0] ? (6'd1 << e.i6) : 6'd0;
      check("ack_valid", 32'(ack_valid), 32'(e.v));
      check("ack_index0", 32'(ack_index[0]), 32'(e.i0));
      check("ack_index1", 32'(ack_index[1]), 32'(e.i1));
      check("ack_one_hot0", 32'(ack_one_hot[0]), 32'(oh0));
      check("ack_one_hot1", 32'(ack_one_hot[1]), 32'(oh1));
      check("ack_mask_all", 32'(ack_mask_all), 32'(e.m));
      check("rr_ptr", 32'(rr_ptr), 32'(e.p));
      check("locked", 32'(locked), 32'(e.l));
      check("w6_valid", 32'(ack_valid6), 32'(e.v6));
      check("w6_index0", 32'(ack_index6[0]), 32'(e.i6));
      check("w6_one_hot0", 32'(ack_one_hot6[0]), 32'(oh6));
      check("w6_rr_ptr", 32'(rr_ptr6), 32'(e.p6));
      $display("txn %0d req=%h valid=%b idx0=%0d idx1=%0d mask=%h ptr=%0d locked=%b | w6 req=%h valid=%b idx0=%0d ptr=%0d",
               txn, e.req, ack_valid, ack_index[0], ack_index[1], ack_mask_all, rr_ptr, locked,
               e.r6, ack_valid6, ack_index6[0], rr_ptr6);
      txn++;
    end
  end

  task automatic step(input logic [7:0] r, input logic rd, input logic h,
                      input logic [1:0] v, input logic [2:0] i0, input logic [2:0] i1,
                      input logic [7:0] m, input logic [2:0] p, input logic l,
                      input logic [5:0] r6, input logic [1:0] v6, input logic [2:0] i6,
                      input logic [2:0] p6);
    exp_t e;
    @(posedge CLK);
    #1;
    req_vec = r; ack_ready = rd; hold_req = h; req6 = r6;
    e.req = r; e.v = v; e.i0 = i0; e.i1 = i1; e.m = m; e.p = p; e.l = l;
    e.r6 = r6; e.v6 = v6; e.i6 = i6; e.p6 = p6;
    sb_q.push_back(e);
  endtask

  initial begin
    nRST = 1'b0; req_vec = '0; ack_ready = 1'b0; hold_req = 1'b0; req6 = '0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    //   req    rdy  hld  valid  i0 i1 mask   ptr lk | req6   v6    i6 p6
    step(8'h00, 0, 0, 2'b00, 0, 0, 8'h00, 0, 0, 6'h00, 2'b00, 0, 0);  // idle after reset
    step(8'hA6, 1, 0, 2'b11, 1, 2, 8'h06, 0, 0, 6'h04, 2'b01, 2, 0);
    step(8'hA6, 1, 0, 2'b11, 5, 7, 8'hA0, 3, 0, 6'h20, 2'b01, 5, 3);
    step(8'hA6, 1, 0, 2'b11, 1, 2, 8'h06, 0, 0, 6'h00, 2'b00, 0, 0);  // both pointers wrapped
    step(8'hA6, 0, 0, 2'b11, 5, 7, 8'hA0, 3, 0, 6'h00, 2'b00, 0, 0);  // stalled
    step(8'hA6, 0, 0, 2'b11, 5, 7, 8'hA0, 3, 0, 6'h00, 2'b00, 0, 0);
    step(8'hA6, 0, 0, 2'b11, 5, 7, 8'hA0, 3, 0, 6'h00, 2'b00, 0, 0);
    step(8'h00, 1, 0, 2'b00, 0, 0, 8'h00, 3, 0, 6'h00, 2'b00, 0, 0);  // ready with no grant
    step(8'hA6, 1, 0, 2'b11, 5, 7, 8'hA0, 3, 0, 6'h00, 2'b00, 0, 0);
    step(8'h11, 1, 1, 2'b11, 0, 4, 8'h11, 0, 0, 6'h00, 2'b00, 0, 0);  // take lock on 0
    step(8'h11, 1, 1, 2'b11, 0, 4, 8'h11, 5, 1, 6'h00, 2'b00, 0, 0);  // locked slot0, wrap slot1
    step(8'h10, 0, 0, 2'b01, 4, 0, 8'h10, 5, 1, 6'h00, 2'b00, 0, 0);  // released lock ignored
    step(8'h40, 1, 0, 2'b01, 6, 0, 8'h40, 5, 0, 6'h00, 2'b00, 0, 0);
    step(8'h00, 0, 0, 2'b00, 0, 0, 8'h00, 7, 0, 6'h00, 2'b00, 0, 0);
    step(8'h40, 1, 1, 2'b01, 6, 0, 8'h40, 7, 0, 6'h00, 2'b00, 0, 0);  // lock on 6
    step(8'h40, 1, 1, 2'b01, 6, 0, 8'h40, 7, 1, 6'h00, 2'b00, 0, 0);  // lock-only commit
    step(8'h41, 0, 0, 2'b11, 6, 0, 8'h41, 7, 1, 6'h00, 2'b00, 0, 0);

    @(negedge CLK);
    #1;
    nRST = 1'b0;
    #1;
    check("async_rst_ptr", 32'(rr_ptr), 32'd0);
    check("async_rst_locked", 32'(locked), 32'd0);
    check("async_rst_idx0", 32'(ack_index[0]), 32'd0);
    check("async_rst_idx1", 32'(ack_index[1]), 32'd6);
    @(posedge CLK);
    #1 nRST = 1'b1;

    step(8'hA6, 1, 0, 2'b11, 1, 2, 8'h06, 0, 0, 6'h00, 2'b00, 0, 0);  // resume from 0

    for (int n = 0; n < 10 && sb_q.size() > 0; n++) @(negedge CLK);
    #1;
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
